// File: rtl/gps_signal_emulator.sv
// gps_signal_emulator
//   Synthetic GPS L1 C/A transmitter used as on-chip correlator stimulus.
//   A nav bit stream is spread by a C/A code (CHIP_DIV clocks per chip,
//   CODE_LEN chips per epoch, EPOCHS_PER_BIT epochs per nav bit). The result
//   is optionally mixed onto a square-wave IF carrier from a 32-bit NCO.
// Ports
//   CLK_16M      sample clock, rising edge
//   rst          synchronous active-high reset
//   enable       1 = transmit (RUN), 0 = idle
//   CACODE       code sequence, chip k = CACODE[k]
//   Phase        starting chip index, sampled on RUN entry (>= CODE_LEN -> 0)
//   nav_bit_in   nav data bit (1 inverts the code)
//   nav_valid    nav_bit_in valid
//   nav_ready    single-entry holding register empty
//   sig_out      registered 1-bit transmitted sample
//   chip_strobe  last clock of each chip
//   epoch_strobe last clock of chip CODE_LEN-1
//   bit_strobe   last clock of each nav bit
//   code_index   chip index currently transmitted
//   nav_underrun bit boundary reached with nothing pending
module gps_signal_emulator #(
  parameter int          CHIP_DIV       = 16,
  parameter int          CODE_LEN       = 1023,
  parameter int          EPOCHS_PER_BIT = 20,
  parameter logic [31:0] CARRIER_STEP   = 32'h0
) (
  input  logic                CLK_16M,
  input  logic                rst,
  input  logic                enable,
  input  logic [CODE_LEN-1:0] CACODE,
  input  logic [9:0]          Phase,
  input  logic                nav_bit_in,
  input  logic                nav_valid,
  output logic                nav_ready,
  output logic                sig_out,
  output logic                chip_strobe,
  output logic                epoch_strobe,
  output logic                bit_strobe,
  output logic [9:0]          code_index,
  output logic                nav_underrun
);
  localparam int DW = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
  localparam int EW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;
  localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [DW-1:0] div_cnt;
  logic [EW-1:0] epoch_cnt;
  logic [31:0]   acc;
  logic          cur_bit, pending, pending_full;
  logic          run, start, accept, code_bit, carrier;

  always_ff @(posedge CLK_16M) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable)  state_nxt = RUN;
      RUN:     if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign run          = (state == RUN);
  assign start        = (state == IDLE) && enable;
  assign nav_ready    = ~pending_full;
  assign accept       = nav_valid & nav_ready;
  assign chip_strobe  = run && (div_cnt == DW'(CHIP_DIV - 1));
  assign epoch_strobe = chip_strobe && (code_index == 10'(CODE_LEN - 1));
  assign bit_strobe   = epoch_strobe && (epoch_cnt == EW'(EPOCHS_PER_BIT - 1));
  // An accept in the boundary cycle is not visible yet: pending_full is
  // still low, so the boundary underruns and the new bit waits a full bit.
  assign nav_underrun = bit_strobe & ~pending_full;
  assign code_bit     = CACODE[code_index[IW-1:0]];
  assign carrier      = acc[31];

  always_ff @(posedge CLK_16M) begin
    if (rst) begin
      div_cnt      <= '0;
      epoch_cnt    <= '0;
      acc          <= '0;
      code_index   <= '0;
      cur_bit      <= 1'b0;
      pending      <= 1'b0;
      pending_full <= 1'b0;
      sig_out      <= 1'b0;
    end else begin
      // Holding register: fill and drain are exclusive (fill needs empty,
      // drain needs full), so a simple priority is enough.
      if (accept) begin
        pending      <= nav_bit_in;
        pending_full <= 1'b1;
      end else if ((start || bit_strobe) && pending_full) begin
        pending_full <= 1'b0;
      end

      if (start) begin
        code_index <= (int'(Phase) < CODE_LEN) ? Phase : 10'd0;
        div_cnt    <= '0;
        epoch_cnt  <= '0;
        acc        <= '0;
        cur_bit    <= pending_full ? pending : 1'b0;
      end else if (run) begin
        acc     <= acc + CARRIER_STEP;
        div_cnt <= chip_strobe ? '0 : div_cnt + 1'b1;
        if (chip_strobe)
          code_index <= (code_index == 10'(CODE_LEN - 1)) ? 10'd0 : code_index + 10'd1;
        if (epoch_strobe)
          epoch_cnt <= bit_strobe ? '0 : epoch_cnt + 1'b1;
        if (bit_strobe && pending_full)
          cur_bit <= pending;
      end

      sig_out <= run & (code_bit ^ cur_bit ^ carrier);
    end
  end
endmodule

// File: tb/tb_gps_signal_emulator.sv
// Bench for gps_signal_emulator. Instance A uses a shrunken code
// (4 clk/chip, 11 chips, 3 epochs/bit) with baseband carrier; instance B
// uses the full-size defaults with an fs/4 carrier.
module tb_gps_signal_emulator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  localparam int AD = 4, AL = 11, AE = 3;
  localparam logic [AL-1:0] CODE_A = 11'b101_1011_0011;

  // instance A
  logic          en_a, nv_a, nb_a, rdy_a, sig_a, chip_a, ep_a, bit_a, und_a;
  logic [9:0]    ph_a, idx_a;
  logic [AL-1:0] code_a;
  // instance B
  logic          en_b, nv_b, nb_b, rdy_b, sig_b, chip_b, ep_b, bit_b, und_b;
  logic [9:0]    ph_b, idx_b;
  logic [1022:0] code_b;

  gps_signal_emulator #(.CHIP_DIV(AD), .CODE_LEN(AL), .EPOCHS_PER_BIT(AE),
                        .CARRIER_STEP(32'h0)) dut_a (
    .CLK_16M(clk), .rst(rst), .enable(en_a), .CACODE(code_a), .Phase(ph_a),
    .nav_bit_in(nb_a), .nav_valid(nv_a), .nav_ready(rdy_a), .sig_out(sig_a),
    .chip_strobe(chip_a), .epoch_strobe(ep_a), .bit_strobe(bit_a),
    .code_index(idx_a), .nav_underrun(und_a));

  gps_signal_emulator #(.CARRIER_STEP(32'h4000_0000)) dut_b (
    .CLK_16M(clk), .rst(rst), .enable(en_b), .CACODE(code_b), .Phase(ph_b),
    .nav_bit_in(nb_b), .nav_valid(nv_b), .nav_ready(rdy_b), .sig_out(sig_b),
    .chip_strobe(chip_b), .epoch_strobe(ep_b), .bit_strobe(bit_b),
    .code_index(idx_b), .nav_underrun(und_b));

  int checks = 0, passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // phase sweep: first epoch strobe / first underrun, cycles from RUN entry
  typedef struct {
    logic [9:0] phase;
    logic [9:0] idx0;
    int         first_epoch;
    int         first_under;
  } vec_t;
  vec_t tbl[5];

  // per-cycle expected outputs of instance A
  typedef struct packed {
    logic       sig, chip, epoch, bitp, under, ready;
    logic [9:0] idx;
  } exp_t;
  exp_t sbq[$];

  // nav stream of the scoreboard run: bit 1 offered at cycle 5, bit 0
  // offered exactly in the boundary cycle 395. Polarity is 1 between the
  // boundaries at 131 and 527.
  function automatic logic cur_bit_at(int m);
    return (m >= 132) && (m <= 527);
  endfunction

  function automatic exp_t model(int n);
    exp_t e;
    logic [AL-1:0] code = CODE_A;
    int chip_no = n / AD;
    e.idx   = 10'(chip_no % AL);
    e.chip  = (n % AD) == AD - 1;
    e.epoch = ((n + 1) % (AD * AL)) == 0;
    e.bitp  = ((n + 1) % (AD * AL * AE)) == 0;
    e.under = (n == 263) || (n == 395);
    e.ready = !(((n >= 6) && (n <= 131)) || ((n >= 396) && (n <= 527)));
    e.sig   = (n == 0) ? 1'b0 : code[((n - 1) / AD) % AL] ^ cur_bit_at(n - 1);
    return e;
  endfunction

  initial begin
    exp_t act, exp_v;
    int fe, fu, bad;
    logic [7:0] car_seen;

    tbl[0] = '{10'd0,    10'd0,  43, 131};
    tbl[1] = '{10'd5,    10'd5,  23, 111};
    tbl[2] = '{10'd10,   10'd10,  3,  91};
    tbl[3] = '{10'd11,   10'd0,  43, 131};
    tbl[4] = '{10'd1023, 10'd0,  43, 131};

    rst = 1'b1; en_a = 0; nv_a = 0; nb_a = 0; ph_a = '0; code_a = CODE_A;
    en_b = 0; nv_b = 0; nb_b = 0; ph_b = '0; code_b = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    check("reset sig_out", int'(sig_a), 0);
    check("reset strobes", int'({chip_a, ep_a, bit_a, und_a}), 0);
    check("reset code_index", int'(idx_a), 0);
    check("reset nav_ready", int'(rdy_a), 1);

    // phase sweep
    foreach (tbl[i]) begin
      rst = 1'b1; tick(); rst = 1'b0;
      ph_a = tbl[i].phase; en_a = 1'b1;
      tick();
      check($sformatf("entry index ph=%0d", tbl[i].phase), int'(idx_a), int'(tbl[i].idx0));
      fe = -1; fu = -1;
      for (int n = 0; n < 300; n++) begin
        if (ep_a  && fe < 0) fe = n;
        if (und_a && fu < 0) fu = n;
        if (fe >= 0 && fu >= 0) break;
        tick();
      end
      check($sformatf("first epoch ph=%0d", tbl[i].phase), fe, tbl[i].first_epoch);
      check($sformatf("first underrun ph=%0d", tbl[i].phase), fu, tbl[i].first_under);
      en_a = 1'b0; tick();
    end

    // cycle-by-cycle scoreboard run from phase 0 with nav traffic
    rst = 1'b1; tick(); rst = 1'b0;
    ph_a = 10'd0; en_a = 1'b1;
    sbq.push_back(model(0));
    tick();
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      act = '{sig: sig_a, chip: chip_a, epoch: ep_a, bitp: bit_a,
              under: und_a, ready: rdy_a, idx: idx_a};
      exp_v = sbq.pop_front();
      if (act != exp_v) begin
        bad++;
        if (bad <= 8) $display("FAIL cycle %0d outputs: got 'h%0h expected 'h%0h", n, act, exp_v);
      end
      nv_a = (n == 5) || (n == 395);
      nb_a = (n == 5);
      if (n < 599) sbq.push_back(model(n + 1));
      tick();
    end
    checks++;
    if (bad == 0) passes++;
    else $display("FAIL scoreboard: got %0d bad cycles expected 0", bad);
    nv_a = 1'b0; nb_a = 1'b0;

    // reset mid-RUN with a bit held pending
    nv_a = 1'b1; nb_a = 1'b1; tick(); nv_a = 1'b0;
    check("pending held", int'(rdy_a), 0);
    tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; en_a = 1'b0;
    check("mid-run reset sig_out", int'(sig_a), 0);
    check("mid-run reset strobes", int'({chip_a, ep_a, bit_a, und_a}), 0);
    check("mid-run reset code_index", int'(idx_a), 0);
    check("mid-run reset nav_ready", int'(rdy_a), 1);
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (chip_a || sig_a || idx_a != 10'd0) bad++;
    end
    check("idle after reset", bad, 0);

    // instance B: full-size code, phase 1000, fs/4 carrier, all-zero code
    ph_b = 10'd1000; en_b = 1'b1;
    tick();
    check("B entry index", int'(idx_b), 1000);
    car_seen = '0; fe = -1; fu = -1;
    for (int n = 0; n < 17000; n++) begin
      if (n >= 1 && n <= 8) car_seen[n - 1] = sig_b;
      if (ep_b) begin
        if (fe < 0) fe = n;
        else if (fu < 0) fu = n;
      end
      if (fe >= 0 && n == fe + 1) check("B index after epoch", int'(idx_b), 0);
      if (fu >= 0) break;
      tick();
    end
    // sig_out cycles 1..8 (LSB first): 0,0,1,1,0,0,1,1
    check("B carrier pattern", int'(car_seen), 'hCC);
    check("B first epoch", fe, 367);
    check("B second epoch", fu, 367 + 16368);
    en_b = 1'b0; tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
